// File: rtl/logic_pkg.sv
// Shared encodings for the RV052B logic unit: group selects and per-group mode codes.
package logic_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SH_W   = 5;

    typedef enum logic [1:0] {
        GRP_NONE  = 2'b00,
        GRP_BIT   = 2'b01,
        GRP_SHIFT = 2'b10,
        GRP_CMP   = 2'b11
    } group_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } sh_mode_e;

    typedef enum logic [2:0] {
        LG_AND  = 3'b000,
        LG_OR   = 3'b001,
        LG_XOR  = 3'b010,
        LG_NOR  = 3'b011,
        LG_ANDN = 3'b100,
        LG_ORN  = 3'b101,
        LG_XNOR = 3'b110,
        LG_PASS = 3'b111
    } lg_mode_e;

    typedef enum logic [2:0] {
        CMP_EQ   = 3'b000,
        CMP_NE   = 3'b001,
        CMP_SLT  = 3'b010,
        CMP_SLTU = 3'b011,
        CMP_SGE  = 3'b100,
        CMP_SGEU = 3'b101,
        CMP_MIN  = 3'b110,
        CMP_MAX  = 3'b111
    } cmp_mode_e;

endpackage

// File: rtl/logic_shifter.sv
// Combinational 32-bit log barrel shifter: SLL, SRL, SRA and rotate-right in five stages.
module logic_shifter
    import logic_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [SH_W-1:0]   sh,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] result_c
);

    logic [DATA_W-1:0] stage;

    // Stage i shifts by 2**i when sh[i] is set; sh=0 passes data through untouched.
    always_comb begin
        stage = data;
        for (int i = 0; i < int'(SH_W); i++) begin
            if (sh[i]) begin
                case (sh_mode_e'(mode))
                    SH_SLL: stage = stage << (1 << i);
                    SH_SRL: stage = stage >> (1 << i);
                    SH_SRA: stage = $signed(stage) >>> (1 << i);
                    SH_ROR: stage = (stage >> (1 << i)) | (stage << (int'(DATA_W) - (1 << i)));
                endcase
            end
        end
        result_c = stage;
    end

endmodule

// File: rtl/logic_unit.sv
// Registered logic/shift/compare unit: result and a one-cycle done pulse one clock after start.
module logic_unit
    import logic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        start,
    input  logic [1:0]  use_part,
    input  logic [1:0]  op_mode1,
    input  logic [2:0]  op_mode2,
    output logic        done,
    output logic [31:0] res
);

    logic [DATA_W-1:0] bit_c;
    logic [DATA_W-1:0] cmp_c;
    logic [DATA_W-1:0] shift_c;
    logic [DATA_W-1:0] next_res_c;
    logic              lt_s_c;
    logic              lt_u_c;

    logic_shifter u_shifter (
        .data     (op1),
        .sh       (op2[SH_W-1:0]),
        .mode     (op_mode1),
        .result_c (shift_c)
    );

    always_comb begin
        bit_c = '0;
        case (lg_mode_e'(op_mode2))
            LG_AND:  bit_c = op1 & op2;
            LG_OR:   bit_c = op1 | op2;
            LG_XOR:  bit_c = op1 ^ op2;
            LG_NOR:  bit_c = ~(op1 | op2);
            LG_ANDN: bit_c = op1 & ~op2;
            LG_ORN:  bit_c = op1 | ~op2;
            LG_XNOR: bit_c = ~(op1 ^ op2);
            LG_PASS: bit_c = op1;
        endcase
    end

    // MIN/MAX return an operand; the rest produce a zero-extended flag.
    always_comb begin
        lt_s_c = $signed(op1) < $signed(op2);
        lt_u_c = op1 < op2;
        cmp_c  = '0;
        case (cmp_mode_e'(op_mode2))
            CMP_EQ:   cmp_c = DATA_W'(op1 == op2);
            CMP_NE:   cmp_c = DATA_W'(op1 != op2);
            CMP_SLT:  cmp_c = DATA_W'(lt_s_c);
            CMP_SLTU: cmp_c = DATA_W'(lt_u_c);
            CMP_SGE:  cmp_c = DATA_W'(!lt_s_c);
            CMP_SGEU: cmp_c = DATA_W'(!lt_u_c);
            CMP_MIN:  cmp_c = lt_s_c ? op1 : op2;
            CMP_MAX:  cmp_c = lt_s_c ? op2 : op1;
        endcase
    end

    always_comb begin
        next_res_c = '0;
        case (group_e'(use_part))
            GRP_NONE:  next_res_c = '0;
            GRP_BIT:   next_res_c = bit_c;
            GRP_SHIFT: next_res_c = shift_c;
            GRP_CMP:   next_res_c = cmp_c;
        endcase
    end

    // Reset wins over start; without start the result holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            done <= 1'b0;
            res  <= '0;
        end else begin
            done <= start;
            if (start) begin
                res <= next_res_c;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit.sv
// Bench for logic_unit: vector table plus hand sequences, checked cycle by cycle via a scoreboard queue.
module tb_logic_unit;

    logic        clk;
    logic        rst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic [1:0]  use_part;
    logic [1:0]  op_mode1;
    logic [2:0]  op_mode2;
    logic        done;
    logic [31:0] res;

    logic_unit dut (
        .clk      (clk),
        .rst      (rst),
        .op1      (op1),
        .op2      (op2),
        .start    (start),
        .use_part (use_part),
        .op_mode1 (op_mode1),
        .op_mode2 (op_mode2),
        .done     (done),
        .res      (res)
    );

    typedef struct {
        string       name;
        logic [1:0]  up;
        logic [1:0]  m1;
        logic [2:0]  m2;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic        done;
        logic [31:0] res;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_res = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(string n, logic [1:0] up, logic [1:0] m1, logic [2:0] m2,
                                logic [31:0] a, logic [31:0] b, logic [31:0] e);
        vec_t v;
        v.name = n; v.up = up; v.m1 = m1; v.m2 = m2; v.a = a; v.b = b; v.exp = e;
        vecs.push_back(v);
    endfunction

    // One clock of stimulus; the expected outputs after the next edge go onto the scoreboard.
    task automatic step(input logic s, input logic r, input vec_t v);
        exp_t e;
        @(negedge clk);
        rst      = r;
        start    = s;
        op1      = s ? v.a : $urandom;
        op2      = s ? v.b : $urandom;
        use_part = s ? v.up : 2'($urandom);
        op_mode1 = (s && v.up == 2'b10) ? v.m1 : 2'($urandom);
        op_mode2 = (s && v.up != 2'b10) ? v.m2 : 3'($urandom);
        e.name   = v.name;
        e.done   = s && r;
        e.res    = !r ? 32'h0 : (s ? v.exp : last_res);
        last_res = e.res;
        sb.push_back(e);
    endtask

    task automatic idle(input logic r, input string n);
        vec_t v;
        v.name = n; v.up = 2'b00; v.m1 = 2'b00; v.m2 = 3'b000;
        v.a = 32'h0; v.b = 32'h0; v.exp = 32'h0;
        step(1'b0, r, v);
    endtask

    // Compare one scoreboard entry just after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (done !== e.done || res !== e.res) begin
                    failures++;
                    $display("FAIL %s: done=%b res=%08h, expected done=%b res=%08h",
                             e.name, done, res, e.done, e.res);
                end
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: bench did not finish, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vec_t v;
        rst = 1'b0; start = 1'b0; op1 = '0; op2 = '0;
        use_part = '0; op_mode1 = '0; op_mode2 = '0;

        add("and",   2'b01, 2'b00, 3'b000, 32'hAAAA_AAAA, 32'h0F0F_0F0F, 32'h0A0A_0A0A);
        add("or",    2'b01, 2'b00, 3'b001, 32'hAAAA_AAAA, 32'h0F0F_0F0F, 32'hAFAF_AFAF);
        add("xor",   2'b01, 2'b00, 3'b010, 32'hAAAA_AAAA, 32'h0F0F_0F0F, 32'hA5A5_A5A5);
        add("nor",   2'b01, 2'b00, 3'b011, 32'hAAAA_AAAA, 32'h0F0F_0F0F, 32'h5050_5050);
        add("andn",  2'b01, 2'b00, 3'b100, 32'hAAAA_AAAA, 32'h0F0F_0F0F, 32'hA0A0_A0A0);
        add("orn",   2'b01, 2'b00, 3'b101, 32'hAAAA_AAAA, 32'h0F0F_0F0F, 32'hFAFA_FAFA);
        add("xnor",  2'b01, 2'b00, 3'b110, 32'hAAAA_AAAA, 32'h0F0F_0F0F, 32'h5A5A_5A5A);
        add("pass",  2'b01, 2'b00, 3'b111, 32'hAAAA_AAAA, 32'h0F0F_0F0F, 32'hAAAA_AAAA);
        add("sll1",  2'b10, 2'b00, 3'b000, 32'hAAAA_AAAA, 32'h0000_0001, 32'h5555_5554);
        add("srl4",  2'b10, 2'b01, 3'b000, 32'hAAAA_AAAA, 32'h0000_0004, 32'h0AAA_AAAA);
        add("srl4hi",2'b10, 2'b01, 3'b000, 32'hAAAA_AAAA, 32'hFFFF_FFE4, 32'h0AAA_AAAA);
        add("sra4",  2'b10, 2'b10, 3'b000, 32'hAAAA_AAAA, 32'h0000_0004, 32'hFAAA_AAAA);
        add("ror4",  2'b10, 2'b11, 3'b000, 32'h0000_000F, 32'h0000_0004, 32'hF000_0000);
        add("ror8",  2'b10, 2'b11, 3'b000, 32'h1234_5678, 32'h0000_0008, 32'h7812_3456);
        add("ror1",  2'b10, 2'b11, 3'b000, 32'hAAAA_AAAA, 32'h0000_0001, 32'h5555_5555);
        add("sll31", 2'b10, 2'b00, 3'b000, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000);
        add("sra31", 2'b10, 2'b10, 3'b000, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF);
        add("srl31", 2'b10, 2'b01, 3'b000, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001);
        for (int m = 0; m < 4; m++)
            add($sformatf("sh0_m%0d", m), 2'b10, 2'(m), 3'b000,
                32'hAAAA_AAAA, 32'h0000_0020, 32'hAAAA_AAAA);
        add("eq0",   2'b11, 2'b00, 3'b000, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0);
        add("eq1",   2'b11, 2'b00, 3'b000, 32'h1234_5678, 32'h1234_5678, 32'h1);
        add("ne",    2'b11, 2'b00, 3'b001, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h1);
        add("slt1",  2'b11, 2'b00, 3'b010, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h1);
        add("slt0",  2'b11, 2'b00, 3'b010, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0);
        add("sltu1", 2'b11, 2'b00, 3'b011, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h1);
        add("sltu5", 2'b11, 2'b00, 3'b011, 32'h0000_0005, 32'hFFFF_FFFF, 32'h1);
        add("sge0",  2'b11, 2'b00, 3'b100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0);
        add("sgeeq", 2'b11, 2'b00, 3'b100, 32'h1234_5678, 32'h1234_5678, 32'h1);
        add("sgeu0", 2'b11, 2'b00, 3'b101, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0);
        add("sgeu1", 2'b11, 2'b00, 3'b101, 32'hFFFF_FFFF, 32'h0000_0005, 32'h1);
        add("min",   2'b11, 2'b00, 3'b110, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
        add("max",   2'b11, 2'b00, 3'b111, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        add("min5",  2'b11, 2'b00, 3'b110, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        add("max5",  2'b11, 2'b00, 3'b111, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0005);
        add("none",  2'b00, 2'b00, 3'b000, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0);

        // Reset state, then the AND / ANDN back-to-back sequence.
        idle(1'b0, "reset0");
        idle(1'b0, "reset1");
        idle(1'b1, "pre_start");
        v = '{"tp_and", 2'b01, 2'b00, 3'b000, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'hAAAA_AAAA};
        step(1'b1, 1'b1, v);
        v = '{"tp_andn", 2'b01, 2'b00, 3'b100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h0000_0000};
        step(1'b1, 1'b1, v);
        idle(1'b1, "tp_hold0");
        idle(1'b1, "tp_hold1");

        // Table: mostly back-to-back, with an idle every third vector to check holding.
        for (int i = 0; i < vecs.size(); i++) begin
            step(1'b1, 1'b1, vecs[i]);
            if (i % 3 == 2) idle(1'b1, {vecs[i].name, "_hold"});
        end
        idle(1'b1, "tbl_end");

        // Reset on the same edge as start discards the operation.
        v = '{"rst_with_start", 2'b01, 2'b00, 3'b111, 32'h1357_9BDF, 32'h0, 32'h1357_9BDF};
        step(1'b1, 1'b0, v);
        idle(1'b1, "post_rst_idle");
        v = '{"post_rst_start", 2'b01, 2'b00, 3'b111, 32'h1357_9BDF, 32'h0, 32'h1357_9BDF};
        step(1'b1, 1'b1, v);
        // Reset right after a result is produced clears it.
        idle(1'b0, "rst_after_result");
        idle(1'b1, "rst_after_idle");
        v = '{"final_xor", 2'b01, 2'b00, 3'b010, 32'hFFFF_0000, 32'h00FF_FF00, 32'hFF00_FF00};
        step(1'b1, 1'b1, v);
        idle(1'b1, "final_hold");

        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
